// File: rtl/md_issue_ctrl.sv
// Issue controller for the iterative mult/div unit: latches operands, pulses the
// start strobe, stalls the pipeline and forms a one-cycle writeback packet.
module md_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned RSTATUS_REG    = 30,
  parameter int unsigned MULT_EXC_CODE  = 4,
  parameter int unsigned DIV_EXC_CODE   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [RD_W-1:0]      lat_rd;
  logic                 lat_div;
  logic [DATA_W-1:0]    exc_code;

  assign exc_code = lat_div ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);

  // Freeze upstream stages from the issuing cycle until the op completes.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:          stall = issue_valid & ~flush;
      S_START, S_BUSY: stall = 1'b1;
      default:         stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      lat_rd       <= '0;
      lat_div      <= 1'b0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_valid && !flush) begin
            md_operandA  <= issue_opA;
            md_operandB  <= issue_opB;
            lat_rd       <= issue_rd;
            lat_div      <= issue_is_div;
            md_ctrl_MULT <= ~issue_is_div;
            md_ctrl_DIV  <= issue_is_div;
            state        <= S_START;
          end
        end
        // Ready may still be asserted from the previous op, so it is not sampled here.
        S_START: begin
          timer <= '0;
          state <= flush ? S_IDLE : S_BUSY;
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
            if (md_resultRDY) begin
              state        <= S_DONE;
              wb_valid     <= 1'b1;
              wb_rd        <= md_exception ? RD_W'(RSTATUS_REG) : lat_rd;
              wb_data      <= md_exception ? exc_code : md_result;
              wb_exception <= md_exception;
            end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
              state        <= S_DONE;
              wb_valid     <= 1'b1;
              wb_rd        <= RD_W'(RSTATUS_REG);
              wb_data      <= exc_code;
              wb_exception <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
